mips5_pipeline: RTL and testbench
=================================

# mips5_pipeline

Five-stage (IF/ID/EX/MEM/WB) MIPS integer pipeline with internal instruction and data memories, used as the top of the lab processor. It has no data ports: the bench preloads both memories through hierarchical paths and watches the register file and the fetched instruction. There is no forwarding and no hazard detection. Software pads data and control hazards with NOPs.

## Interface
- No parameters. Memory depth is fixed at 256 words × 32 bits for each memory.
- `clk`  input  1  single rising-edge clock.
- `reset`  input  1  synchronous, active-low reset.
  - `reset = 0` at a rising edge resets the core.
  - `reset = 1` runs.
- Required hierarchy, so benches can probe and preload:
  - `if0.instrout[31:0]`: the IF/ID instruction register.
  - `if0.im0.mem[0:255]`: instruction memory.
  - `id0.rf0.gpr[0:31]`: register file.
  - `mem0.dm0.mem[0:255]`: data memory.
  - `ex0` and `wb0` are the remaining stage instances.

## Operation
- Supported instructions:
  - R-type, opcode 000000. Funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed).
  - lw 100011, sw 101011, beq 000100.
  - The 32'h0 word is a NOP.
  - Any other opcode is executed as a NOP: no register write, no memory write, no branch.
- Register r0 reads as 0 and writes to it are discarded.
- Register file reads are combinational in ID with write-through. If WB writes register X in the same cycle that ID reads X, ID gets the new value.
- Immediates are sign-extended to 32 bits.
- lw/sw address = rs + sext(imm).
- beq target = PC+4 + (sext(imm) << 2).
- All arithmetic is 32-bit wraparound. Overflow is ignored.
- Both memories are word-addressed by `addr[9:2]`. Bits [1:0] and bits above 9 are ignored, so addresses wrap modulo 1 KiB.
- Instruction memory is read-only and combinationally read.
- Data memory:
  - Combinational read.
  - Synchronous write in MEM when sw is in MEM.
- Branches:
  - beq is resolved in MEM (rs == rt computed in EX).
  - When it is taken, the PC loads the target at the end of that cycle.
  - The three instructions behind it are not flushed. Software places three NOPs after each beq.
- Destination register is rd for R-type and rt for lw.
- Write-back mux selects the memory read data for lw and the ALU result otherwise.
- Reset clears:
  - PC to 0.
  - All pipeline registers, including `instrout`, to 0 (NOPs).
  - All 32 GPRs to 0.
- Memories are never reset.

## Timing
- All state updates on the rising edge of `clk`.
- Reset is synchronous. Asserting it mid-program discards all in-flight instructions at that edge, and fetch restarts at address 0 on the first edge with `reset = 1`.
- Fetch of word 0:
  - The first edge with `reset = 1` latches `mem[0]` into `instrout`.
  - Each later edge advances by one word.
- An instruction is in IF on edge N and leaves WB on edge N+4. It is visible in `gpr` after edge N+4.
- Data hazard rule:
  - A consumer must sit at least 3 instructions after its producer. With write-through, two NOPs in between suffice.
  - lw followed by a dependent use needs the same spacing.
- PC increments by 4 every cycle. There are no stalls.

## Structure
- Shared package `mips_pkg` holds:
  - Opcode and funct constants.
  - An ALU-op enumeration.
  - Widths: DATA_W = 32, REG_ADDR_W = 5, MEM_DEPTH = 256.
  - Pipeline-register struct typedefs: `if_id_t`, `id_ex_t`, `ex_mem_t`, `mem_wb_t`.
- Stage sub-modules `if_stage` (`if0`, contains `im0`), `id_stage` (`id0`, contains `rf0` and control decode), `ex_stage` (`ex0`, contains the ALU), `mem_stage` (`mem0`, contains `dm0`), and `wb_stage` (`wb0`).
- Generic `mem_word` sub-module instanced twice (`im0` and `dm0`). `regfile` sub-module instanced as `rf0`.

## Test plan
- **Reset:** hold `reset = 0` for one edge, then release.
  - During reset: `instrout = 0`, r1 = r2 = r3 = 0.
  - First edge after release: `instrout = mem[0]`.
- **Loads:** data `mem[0] = 5`, `mem[1] = 7`. Program `lw r1,0(r0)`; `lw r2,4(r0)`; NOP, NOP; `add r3,r1,r2`.
  - r1 = 5 after edge 5.
  - r2 = 7 after edge 6.
  - r3 = 12 after edge 9.
  - (Edges counted from release.)
- **ALU ops:** r1 = 5, r2 = 7.
  - `sub` gives 0xFFFFFFFE.
  - `and` gives 5.
  - `or` gives 7.
  - `slt r3,r2,r1` gives 0.
  - `slt r3,r1,r2` gives 1.
- **Store/load round trip:** `sw r3,8(r0)`, NOPs, then `lw r4,8(r0)`. Requires `dm0.mem[2] == 12` and r4 = 12.
- **Branches:**
  - Taken `beq r1,r1,+4` with three NOP pads: skips four words, and the skipped `add` does not change r3.
  - Not-taken `beq r1,r2`: falls through.
- **Writes to r0 and wrap:** `add r0,r1,r2` leaves `gpr[0] = 0`. A fetch past word 255 wraps to word 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants, ALU-op encoding and pipeline-register layouts for the five-stage MIPS core.
// Imported by every stage; holds no logic beyond a sign-extension helper.
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_DEPTH  = 256;
  localparam int MEM_AW     = $clog2(MEM_DEPTH);
  localparam int NREG       = 1 << REG_ADDR_W;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] instr;
  } if_id_t;

  typedef struct packed {
    alu_op_e               alu_op;
    logic                  use_imm;
    logic                  reg_we;
    logic                  mem_rd;
    logic                  mem_we;
    logic                  branch;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     pc4;
  } id_ex_t;

  typedef struct packed {
    logic                  reg_we;
    logic                  mem_rd;
    logic                  mem_we;
    logic                  br_taken;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     st_dat;
    logic [DATA_W-1:0]     br_target;
  } ex_mem_t;

  typedef struct packed {
    logic                  reg_we;
    logic                  mem_rd;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     rd_dat;
  } mem_wb_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction
endpackage

// File: rtl/mips5_pipeline_if.sv
// Observation bundle from the core: current PC, IF/ID instruction and the write-back port.
// Purely driven by the core; observers never push back.
interface mips5_pipeline_if;
  import mips_pkg::*;
  logic [DATA_W-1:0]     pc;
  logic [DATA_W-1:0]     instr;
  logic                  wb_vld;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_dat;

  modport master (output pc, instr, wb_vld, wb_addr, wb_dat);
  modport slave  (input  pc, instr, wb_vld, wb_addr, wb_dat);
endinterface

// File: rtl/ex_stage.sv
// Execute: ALU, branch compare and target adder, EX/MEM register (one cycle).
// The branch decision is only registered here; it takes effect from MEM.
module ex_stage
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  id_ex_t  id_ex_i,
  output ex_mem_t ex_mem_o
);
  logic [DATA_W-1:0] op_a, op_b, alu_res;
  ex_mem_t           ex_mem_d, ex_mem_q;

  assign op_a = id_ex_i.rs_val;
  assign op_b = id_ex_i.use_imm ? id_ex_i.imm : id_ex_i.rt_val;

  always_comb begin
    alu_res = op_a + op_b;
    case (id_ex_i.alu_op)
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    ex_mem_d           = '0;
    ex_mem_d.reg_we    = id_ex_i.reg_we;
    ex_mem_d.mem_rd    = id_ex_i.mem_rd;
    ex_mem_d.mem_we    = id_ex_i.mem_we;
    ex_mem_d.dst       = id_ex_i.dst;
    ex_mem_d.alu_res   = alu_res;
    ex_mem_d.st_dat    = id_ex_i.rt_val;
    ex_mem_d.br_taken  = id_ex_i.branch && (id_ex_i.rs_val == id_ex_i.rt_val);
    ex_mem_d.br_target = id_ex_i.pc4 + (id_ex_i.imm << 2);
  end

  always_ff @(posedge clk) begin
    if (!reset) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

  assign ex_mem_o = ex_mem_q;
endmodule

// File: rtl/id_stage.sv
// Decode: control generation, register read with write-through, ID/EX register (one cycle).
// Unsupported opcodes and R-type functs decode to a NOP.
module id_stage
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  if_id_t                if_id_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output id_ex_t                id_ex_o
);
  logic [5:0]            op, fn;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     rs_val, rt_val;
  id_ex_t                id_ex_d, id_ex_q;

  assign op = if_id_i.instr[31:26];
  assign rs = if_id_i.instr[25:21];
  assign rt = if_id_i.instr[20:16];
  assign rd = if_id_i.instr[15:11];
  assign fn = if_id_i.instr[5:0];

  regfile rf0 (
    .clk   (clk),
    .reset (reset),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (wb_we_i),
    .wa_i  (wb_addr_i),
    .wd_i  (wb_dat_i)
  );

  always_comb begin
    id_ex_d        = '0;
    id_ex_d.rs_val = rs_val;
    id_ex_d.rt_val = rt_val;
    id_ex_d.imm    = sext16(if_id_i.instr[15:0]);
    id_ex_d.pc4    = if_id_i.pc4;
    case (op)
      OP_RTYPE: begin
        id_ex_d.dst    = rd;
        id_ex_d.reg_we = 1'b1;
        case (fn)
          FN_ADD:  id_ex_d.alu_op = ALU_ADD;
          FN_SUB:  id_ex_d.alu_op = ALU_SUB;
          FN_AND:  id_ex_d.alu_op = ALU_AND;
          FN_OR:   id_ex_d.alu_op = ALU_OR;
          FN_SLT:  id_ex_d.alu_op = ALU_SLT;
          default: id_ex_d.reg_we = 1'b0;
        endcase
      end
      OP_LW: begin
        id_ex_d.dst     = rt;
        id_ex_d.use_imm = 1'b1;
        id_ex_d.reg_we  = 1'b1;
        id_ex_d.mem_rd  = 1'b1;
      end
      OP_SW: begin
        id_ex_d.use_imm = 1'b1;
        id_ex_d.mem_we  = 1'b1;
      end
      OP_BEQ:  id_ex_d.branch = 1'b1;
      default: id_ex_d.branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  assign id_ex_o = id_ex_q;
endmodule

// File: rtl/if_stage.sv
// Fetch: PC register, instruction memory and the IF/ID register (one cycle, no stalls).
// A taken branch from MEM overrides the sequential PC at the end of that cycle.
module if_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              br_taken_i,
  input  logic [DATA_W-1:0] br_target_i,
  output if_id_t            if_id_o,
  output logic [DATA_W-1:0] pc_o
);
  logic [DATA_W-1:0] pc_q, pc_d, pc4_q, fetch_dat;
  logic [DATA_W-1:0] instrout;

  mem_word im0 (
    .clk    (clk),
    .we_i   (1'b0),
    .addr_i (pc_q[MEM_AW+1:2]),
    .wdat_i ('0),
    .rdat_o (fetch_dat)
  );

  assign pc_d = br_taken_i ? br_target_i : pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= '0;
      pc4_q    <= '0;
      instrout <= '0;
    end else begin
      pc_q     <= pc_d;
      pc4_q    <= pc_q + 32'd4;
      instrout <= fetch_dat;
    end
  end

  assign if_id_o.pc4   = pc4_q;
  assign if_id_o.instr = instrout;
  assign pc_o          = pc_q;
endmodule

// File: rtl/mem_stage.sv
// Memory: data memory access, branch redirect to fetch, MEM/WB register (one cycle).
// Stores commit on the edge that ends the MEM cycle.
module mem_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_t           ex_mem_i,
  output logic              br_taken_o,
  output logic [DATA_W-1:0] br_target_o,
  output mem_wb_t           mem_wb_o
);
  logic [DATA_W-1:0] rd_dat;
  mem_wb_t           mem_wb_d, mem_wb_q;

  mem_word dm0 (
    .clk    (clk),
    .we_i   (ex_mem_i.mem_we),
    .addr_i (ex_mem_i.alu_res[MEM_AW+1:2]),
    .wdat_i (ex_mem_i.st_dat),
    .rdat_o (rd_dat)
  );

  always_comb begin
    mem_wb_d         = '0;
    mem_wb_d.reg_we  = ex_mem_i.reg_we;
    mem_wb_d.mem_rd  = ex_mem_i.mem_rd;
    mem_wb_d.dst     = ex_mem_i.dst;
    mem_wb_d.alu_res = ex_mem_i.alu_res;
    mem_wb_d.rd_dat  = rd_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset) mem_wb_q <= '0;
    else        mem_wb_q <= mem_wb_d;
  end

  assign br_taken_o  = ex_mem_i.br_taken;
  assign br_target_o = ex_mem_i.br_target;
  assign mem_wb_o    = mem_wb_q;
endmodule

// File: rtl/mem_word.sv
// Word memory, combinational read, synchronous write; contents are never reset.
// Addressed by word index; callers drop the byte-offset bits.
module mem_word
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdat_i,
  output logic [DATA_W-1:0] rdat_o
);
  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  assign rdat_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdat_i;
  end
endmodule

// File: rtl/regfile.sv
// 32 x 32 register file: two combinational read ports with write-through, one write port.
// r0 is hard-wired to zero on read and writes to it are dropped.
module regfile
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  input  logic [REG_ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0]     rd1_o,
  output logic [DATA_W-1:0]     rd2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0]     wd_i
);
  logic [DATA_W-1:0] gpr [0:NREG-1];

  always_comb begin
    rd1_o = gpr[ra1_i];
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
  end

  always_comb begin
    rd2_o = gpr[ra2_i];
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
    if (ra2_i == '0) rd2_o = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      gpr[wa_i] <= wd_i;
    end
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back: selects load data or ALU result for the register-file write port.
// Combinational; the register file commits on the edge ending this cycle.
module wb_stage
  import mips_pkg::*;
(
  input  mem_wb_t               mem_wb_i,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0]     dat_o
);
  assign we_o   = mem_wb_i.reg_we;
  assign addr_o = mem_wb_i.dst;
  assign dat_o  = mem_wb_i.mem_rd ? mem_wb_i.rd_dat : mem_wb_i.alu_res;
endmodule

// File: rtl/mips5_pipeline.sv
// Five-stage MIPS integer core; fetch-to-writeback is five edges, no stalls, no forwarding.
// Hazards are left to software; the debug bundle only reports state and never stalls the core.
module mips5_pipeline
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mips5_pipeline_if.master  dbg
);
  if_id_t                if_id;
  id_ex_t                id_ex;
  ex_mem_t               ex_mem;
  mem_wb_t               mem_wb;
  logic                  br_taken, wb_we;
  logic [DATA_W-1:0]     br_target, wb_dat, pc;
  logic [REG_ADDR_W-1:0] wb_addr;

  if_stage if0 (
    .clk         (clk),
    .reset       (reset),
    .br_taken_i  (br_taken),
    .br_target_i (br_target),
    .if_id_o     (if_id),
    .pc_o        (pc)
  );

  id_stage id0 (
    .clk       (clk),
    .reset     (reset),
    .if_id_i   (if_id),
    .wb_we_i   (wb_we),
    .wb_addr_i (wb_addr),
    .wb_dat_i  (wb_dat),
    .id_ex_o   (id_ex)
  );

  ex_stage ex0 (
    .clk      (clk),
    .reset    (reset),
    .id_ex_i  (id_ex),
    .ex_mem_o (ex_mem)
  );

  mem_stage mem0 (
    .clk         (clk),
    .reset       (reset),
    .ex_mem_i    (ex_mem),
    .br_taken_o  (br_taken),
    .br_target_o (br_target),
    .mem_wb_o    (mem_wb)
  );

  wb_stage wb0 (
    .mem_wb_i (mem_wb),
    .we_o     (wb_we),
    .addr_o   (wb_addr),
    .dat_o    (wb_dat)
  );

  assign dbg.pc      = pc;
  assign dbg.instr   = if_id.instr;
  assign dbg.wb_vld  = wb_we;
  assign dbg.wb_addr = wb_addr;
  assign dbg.wb_dat  = wb_dat;
endmodule

// File: tb/tb_mips5_pipeline.sv
// Bench for mips5_pipeline: preloads memories hierarchically, scoreboards every write-back
// and probes registers, data memory and the IF/ID instruction at specific edges.
module tb_mips5_pipeline;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100;
  localparam logic [5:0] T_ADD = 6'b100000, T_SUB = 6'b100010, T_AND = 6'b100100;
  localparam logic [5:0] T_OR = 6'b100101, T_SLT = 6'b101010;
  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  wb_t         sb_q[$];
  logic [31:0] prog[$];

  mips5_pipeline_if dbg_if();
  mips5_pipeline dut (.clk(clk), .reset(reset), .dbg(dbg_if));

  always #5 clk = ~clk;

  function automatic logic [31:0] rop(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] iop(input logic [5:0] op, input logic [4:0] rt, rs,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Every register-file write request seen while running must match the next expected one.
  always @(negedge clk) begin : monitor
    wb_t e;
    if (reset && dbg_if.wb_vld === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got r%0d=%h, expected no write", dbg_if.wb_addr, dbg_if.wb_dat);
      end else begin
        e = sb_q.pop_front();
        if (dbg_if.wb_addr !== e.a || dbg_if.wb_dat !== e.d) begin
          errors++;
          $display("FAIL wb_write: got r%0d=%h, expected r%0d=%h",
                   dbg_if.wb_addr, dbg_if.wb_dat, e.a, e.d);
        end
      end
    end
  end

  task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    sb_q.push_back(e);
  endtask

  // Resets the core for one edge while loading prog; returns #1 after the reset edge.
  task automatic start_prog(input bit fill);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i < prog.size()) dut.if0.im0.mem[i] = prog[i];
      else if (fill)       dut.if0.im0.mem[i] = 32'hFC00_0000 | 32'(i);
      else                 dut.if0.im0.mem[i] = NOP;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending writes, expected 0", name, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_reset();
    prog.delete();
    prog.push_back(32'hFC00_0001);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.if0.im0.mem[i] = (i == 0) ? prog[0] : NOP;
    @(posedge clk);
    #1;
    checks++;
    if (dut.if0.instrout !== 32'h0) begin
      errors++;
      $display("FAIL reset_instrout: got %h, expected %h", dut.if0.instrout, 32'h0);
    end
    for (int r = 1; r <= 3; r++) begin
      checks++;
      if (dut.id0.rf0.gpr[r] !== 32'h0) begin
        errors++;
        $display("FAIL reset_gpr%0d: got %h, expected %h", r, dut.id0.rf0.gpr[r], 32'h0);
      end
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (dut.if0.instrout !== 32'hFC00_0001) begin
      errors++;
      $display("FAIL reset_first_fetch: got %h, expected %h", dut.if0.instrout, 32'hFC00_0001);
    end
  endtask

  task automatic test_loads();
    dut.mem0.dm0.mem[0] = 32'd5;
    dut.mem0.dm0.mem[1] = 32'd7;
    prog.delete();
    prog.push_back(iop(T_LW, 5'd1, 5'd0, 16'd0));
    prog.push_back(iop(T_LW, 5'd2, 5'd0, 16'd4));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rop(T_ADD, 5'd3, 5'd1, 5'd2));
    expect_wb(5'd1, 32'd5); expect_wb(5'd2, 32'd7); expect_wb(5'd3, 32'd12);
    start_prog(1'b0);
    step(4);
    checks++;
    if (dut.id0.rf0.gpr[1] !== 32'd0) begin
      errors++; $display("FAIL loads_r1_early: got %h, expected %h", dut.id0.rf0.gpr[1], 32'd0);
    end
    step(1);
    checks++;
    if (dut.id0.rf0.gpr[1] !== 32'd5) begin
      errors++; $display("FAIL loads_r1: got %h, expected %h", dut.id0.rf0.gpr[1], 32'd5);
    end
    step(1);
    checks++;
    if (dut.id0.rf0.gpr[2] !== 32'd7) begin
      errors++; $display("FAIL loads_r2: got %h, expected %h", dut.id0.rf0.gpr[2], 32'd7);
    end
    step(2);
    checks++;
    if (dut.id0.rf0.gpr[3] !== 32'd0) begin
      errors++; $display("FAIL loads_r3_early: got %h, expected %h", dut.id0.rf0.gpr[3], 32'd0);
    end
    step(1);
    checks++;
    if (dut.id0.rf0.gpr[3] !== 32'd12) begin
      errors++; $display("FAIL loads_r3: got %h, expected %h", dut.id0.rf0.gpr[3], 32'd12);
    end
    step(4);
    check_drained("loads");
  endtask

  task automatic test_alu();
    logic [31:0] exp_v [3:7];
    exp_v[3] = 32'hFFFF_FFFE; exp_v[4] = 32'd5; exp_v[5] = 32'd7;
    exp_v[6] = 32'd0;         exp_v[7] = 32'd1;
    prog.delete();
    prog.push_back(iop(T_LW, 5'd1, 5'd0, 16'd0));
    prog.push_back(iop(T_LW, 5'd2, 5'd0, 16'd4));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rop(T_SUB, 5'd3, 5'd1, 5'd2));
    prog.push_back(rop(T_AND, 5'd4, 5'd1, 5'd2));
    prog.push_back(rop(T_OR,  5'd5, 5'd1, 5'd2));
    prog.push_back(rop(T_SLT, 5'd6, 5'd2, 5'd1));
    prog.push_back(rop(T_SLT, 5'd7, 5'd1, 5'd2));
    expect_wb(5'd1, 32'd5); expect_wb(5'd2, 32'd7);
    for (int r = 3; r <= 7; r++) expect_wb(5'(r), exp_v[r]);
    start_prog(1'b0);
    step(14);
    for (int r = 3; r <= 7; r++) begin
      checks++;
      if (dut.id0.rf0.gpr[r] !== exp_v[r]) begin
        errors++;
        $display("FAIL alu_r%0d: got %h, expected %h", r, dut.id0.rf0.gpr[r], exp_v[r]);
      end
    end
    check_drained("alu");
  endtask

  task automatic test_store_load();
    dut.mem0.dm0.mem[2] = 32'd0;
    prog.delete();
    prog.push_back(iop(T_LW, 5'd1, 5'd0, 16'd0));
    prog.push_back(iop(T_LW, 5'd2, 5'd0, 16'd4));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rop(T_ADD, 5'd3, 5'd1, 5'd2));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(iop(T_SW, 5'd3, 5'd0, 16'd8));
    prog.push_back(NOP);
    prog.push_back(iop(T_LW, 5'd4, 5'd0, 16'd8));
    expect_wb(5'd1, 32'd5); expect_wb(5'd2, 32'd7);
    expect_wb(5'd3, 32'd12); expect_wb(5'd4, 32'd12);
    start_prog(1'b0);
    step(16);
    checks++;
    if (dut.mem0.dm0.mem[2] !== 32'd12) begin
      errors++; $display("FAIL store_dmem2: got %h, expected %h", dut.mem0.dm0.mem[2], 32'd12);
    end
    checks++;
    if (dut.id0.rf0.gpr[4] !== 32'd12) begin
      errors++; $display("FAIL store_r4: got %h, expected %h", dut.id0.rf0.gpr[4], 32'd12);
    end
    check_drained("store");
  endtask

  task automatic test_branch();
    prog.delete();
    prog.push_back(iop(T_LW, 5'd1, 5'd0, 16'd0));
    prog.push_back(iop(T_LW, 5'd2, 5'd0, 16'd4));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(iop(T_BEQ, 5'd1, 5'd1, 16'd4));
    prog.push_back(NOP); prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rop(T_ADD, 5'd3, 5'd1, 5'd2));
    prog.push_back(rop(T_AND, 5'd4, 5'd1, 5'd2));
    prog.push_back(iop(T_BEQ, 5'd2, 5'd1, 16'd4));
    prog.push_back(NOP); prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rop(T_ADD, 5'd6, 5'd1, 5'd2));
    prog.push_back(NOP);
    expect_wb(5'd1, 32'd5); expect_wb(5'd2, 32'd7);
    expect_wb(5'd4, 32'd5); expect_wb(5'd6, 32'd12);
    start_prog(1'b0);
    step(9);
    checks++;
    if (dut.if0.instrout !== prog[9]) begin
      errors++; $display("FAIL branch_target_fetch: got %h, expected %h", dut.if0.instrout, prog[9]);
    end
    step(12);
    checks++;
    if (dut.id0.rf0.gpr[3] !== 32'd0) begin
      errors++; $display("FAIL branch_skipped_r3: got %h, expected %h", dut.id0.rf0.gpr[3], 32'd0);
    end
    checks++;
    if (dut.id0.rf0.gpr[4] !== 32'd5) begin
      errors++; $display("FAIL branch_target_r4: got %h, expected %h", dut.id0.rf0.gpr[4], 32'd5);
    end
    checks++;
    if (dut.id0.rf0.gpr[6] !== 32'd12) begin
      errors++; $display("FAIL branch_fallthru_r6: got %h, expected %h", dut.id0.rf0.gpr[6], 32'd12);
    end
    check_drained("branch");
  endtask

  task automatic test_r0_wrap();
    prog.delete();
    prog.push_back(iop(T_LW, 5'd1, 5'd0, 16'd0));
    prog.push_back(iop(T_LW, 5'd2, 5'd0, 16'd4));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rop(T_ADD, 5'd0, 5'd1, 5'd2));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rop(T_ADD, 5'd5, 5'd0, 5'd1));
    expect_wb(5'd1, 32'd5); expect_wb(5'd2, 32'd7);
    expect_wb(5'd0, 32'd12); expect_wb(5'd5, 32'd5);
    start_prog(1'b1);
    step(12);
    checks++;
    if (dut.id0.rf0.gpr[0] !== 32'd0) begin
      errors++; $display("FAIL r0_write: got %h, expected %h", dut.id0.rf0.gpr[0], 32'd0);
    end
    checks++;
    if (dut.id0.rf0.gpr[5] !== 32'd5) begin
      errors++; $display("FAIL r0_read: got %h, expected %h", dut.id0.rf0.gpr[5], 32'd5);
    end
    check_drained("r0");
    step(244);
    checks++;
    if (dut.if0.instrout !== 32'hFC00_00FF) begin
      errors++; $display("FAIL wrap_word255: got %h, expected %h", dut.if0.instrout, 32'hFC00_00FF);
    end
    step(1);
    checks++;
    if (dut.if0.instrout !== prog[0]) begin
      errors++; $display("FAIL wrap_word0: got %h, expected %h", dut.if0.instrout, prog[0]);
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (dut.if0.instrout !== 32'h0) begin
      errors++; $display("FAIL midreset_instrout: got %h, expected %h", dut.if0.instrout, 32'h0);
    end
    checks++;
    if (dut.id0.rf0.gpr[1] !== 32'h0) begin
      errors++; $display("FAIL midreset_gpr1: got %h, expected %h", dut.id0.rf0.gpr[1], 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_alu();
    test_store_load();
    test_branch();
    test_r0_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
